// File: rtl/shift_iter.sv
// Multicycle SLL/SRA shifter: resolves one power-of-two stage (16,8,4,2,1) per clock.
// Optional macro SHIFT_ITER_EARLY_EXIT_EN skips stages whose shamt bit is clear.
module shift_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_shift,
  input  logic             op,
  input  logic [WIDTH-1:0] data_operand,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int CW = $clog2(SHW);
  localparam logic [CW-1:0] LAST = CW'(SHW - 1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  if (WIDTH != 32 || SHW != 5) begin : g_bad_cfg
    $error("shift_iter: WIDTH must be 32 and SHW must be 5");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_shamt;
  logic             r_op;
  logic             r_sign;
  logic [WIDTH-1:0] r_result;
  logic             r_rdy;
  logic             r_busy;

  logic [CW-1:0]    w_idx;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_stage;

  // Stage k shifts by 16>>k when shamt[4-k] is set; SRA fills from the latched sign.
  assign w_idx     = LAST - r_cnt;
  assign w_amt     = {1'b1, {(SHW-1){1'b0}}} >> r_cnt;
  assign w_shifted = r_op ? ((r_work >> w_amt) | (r_sign ? ~(ONES >> w_amt) : {WIDTH{1'b0}}))
                          : (r_work << w_amt);
  assign w_stage   = r_shamt[w_idx] ? w_shifted : r_work;

`ifdef SHIFT_ITER_EARLY_EXIT_EN
  // Returns {found, k} for the lowest stage k >= from whose shamt bit is set.
  function automatic logic [CW:0] f_next_stage(input logic [SHW-1:0] s, input logic [CW-1:0] from);
    logic [CW:0] res;
    res = {1'b0, {CW{1'b0}}};
    for (int i = SHW - 1; i >= 0; i--) begin
      if (i >= int'(from) && s[SHW-1-i]) begin
        res = {1'b1, CW'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [CW:0] w_first;
  logic [CW:0] w_next;
  assign w_first = f_next_stage(shamt, {CW{1'b0}});
  assign w_next  = f_next_stage(r_shamt, r_cnt + {{(CW-1){1'b0}}, 1'b1});
`endif

  // Control FSM with registered result/handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_work   <= {WIDTH{1'b0}};
      r_shamt  <= {SHW{1'b0}};
      r_op     <= 1'b0;
      r_sign   <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        // DONE accepts a new start so ops can run back-to-back.
        ST_IDLE, ST_DONE: begin
          if (ctrl_shift) begin
            r_work  <= data_operand;
            r_shamt <= shamt;
            r_op    <= op;
            r_sign  <= data_operand[WIDTH-1];
`ifdef SHIFT_ITER_EARLY_EXIT_EN
            r_cnt <= w_first[CW-1:0];
            if (w_first[CW]) begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_result <= data_operand;
              r_rdy    <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_DONE;
            end
`else
            r_cnt   <= {CW{1'b0}};
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_work <= w_stage;
`ifdef SHIFT_ITER_EARLY_EXIT_EN
          if (r_cnt == LAST || !w_next[CW]) begin
`else
          if (r_cnt == LAST) begin
`endif
            r_result <= w_stage;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
`ifdef SHIFT_ITER_EARLY_EXIT_EN
            r_cnt <= w_next[CW-1:0];
`else
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_resultRDY = r_rdy;
  assign data_busy      = r_busy;

endmodule
